// File: rtl/pl_arb_pkg.sv
// Shared types and constants for the pipelined-CPU memory arbiter.
package pl_arb_pkg;

    // Arbiter sequencing: one outstanding memory transaction at a time.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_e;

    // Which requester owns the transaction currently in flight.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Width of the latency and starvation counters (covers 1..15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/pl_lat_counter.sv
// Loadable down-counter that flags zero; it times the memory read latency.
module pl_lat_counter
    import pl_arb_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] value_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over counting; counting stops at zero so the flag stays stable.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register, cleared by the asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pl_mem_arbiter.sv
// Arbitrates the CPU fetch (I) and data (D) ports onto one single-port memory.
module pl_mem_arbiter
    import pl_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          stall
);

    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_e       state_q;
    owner_e           owner_q;
    logic [CNT_W-1:0] starve_q;
    logic             i_ack_q;
    logic             d_ack_q;
    logic             mem_en_q;
    logic             mem_we_q;
    logic [AW-1:0]    mem_addr_q;
    logic [DW-1:0]    mem_wdata_q;
    logic [DW-1:0]    i_rdata_q;
    logic [DW-1:0]    d_rdata_q;

    logic             grant_d;
    logic             lat_zero;

    // D normally wins a tie; once it has starved I for STARVE_MAX grants, I goes first.
    always_comb begin
        grant_d = d_req & (~i_req | (starve_q != STARVE_LIM));
    end

    pl_lat_counter #(
        .W (CNT_W)
    ) u_lat (
        .clock   (clock),
        .reset   (reset),
        .load_i  (state_q == ISSUE),
        .en_i    (state_q == WAIT),
        .value_i (LAT_LOAD),
        .zero_o  (lat_zero)
    );

    // Transaction sequencer: grant in IDLE, strobe in ISSUE, wait out latency, ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_I;
            starve_q    <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            i_ack_q  <= 1'b0;
            d_ack_q  <= 1'b0;
            mem_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        state_q  <= ISSUE;
                        mem_en_q <= 1'b1;
                        if (grant_d) begin
                            owner_q     <= OWN_D;
                            mem_addr_q  <= d_addr;
                            mem_wdata_q <= d_wdata;
                            mem_we_q    <= d_we;
                            if (i_req && (starve_q != STARVE_LIM)) begin
                                starve_q <= starve_q + 1'b1;
                            end
                        end else begin
                            owner_q    <= OWN_I;
                            mem_addr_q <= i_addr;
                            mem_we_q   <= 1'b0;
                            starve_q   <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_we_q) begin
                        state_q <= ACK;
                        i_ack_q <= (owner_q == OWN_I);
                        d_ack_q <= (owner_q == OWN_D);
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_zero) begin
                        state_q <= ACK;
                        i_ack_q <= (owner_q == OWN_I);
                        d_ack_q <= (owner_q == OWN_D);
                        if (owner_q == OWN_I) begin
                            i_rdata_q <= mem_rdata;
                        end else begin
                            d_rdata_q <= mem_rdata;
                        end
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);
    assign stall     = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_pl_mem_arbiter.sv
// Directed bench for pl_mem_arbiter: three instances share stimulus and differ in
// read latency (A: 2, B: 4, C: 1); each scenario checks the instance it targets.
module tb_pl_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        iReq;
    logic [31:0] iAddr;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [31:0] memRdata;

    logic        iAckA, dAckA, memEnA, memWeA, busyA, stallA;
    logic [31:0] iRdataA, dRdataA, memAddrA, memWdataA;
    logic        iAckB, dAckB, memEnB, memWeB, busyB, stallB;
    logic [31:0] iRdataB, dRdataB, memAddrB, memWdataB;
    logic        iAckC, dAckC, memEnC, memWeC, busyC, stallC;
    logic [31:0] iRdataC, dRdataC, memAddrC, memWdataC;

    int nChecks = 0;
    int nFails  = 0;

    pl_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_MAX(3)) u_dutA (
        .clock(clock), .reset(reset),
        .i_req(iReq), .i_addr(iAddr), .i_ack(iAckA), .i_rdata(iRdataA),
        .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
        .d_ack(dAckA), .d_rdata(dRdataA),
        .mem_en(memEnA), .mem_we(memWeA), .mem_addr(memAddrA), .mem_wdata(memWdataA),
        .mem_rdata(memRdata), .busy(busyA), .stall(stallA)
    );

    pl_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(4), .STARVE_MAX(3)) u_dutB (
        .clock(clock), .reset(reset),
        .i_req(iReq), .i_addr(iAddr), .i_ack(iAckB), .i_rdata(iRdataB),
        .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
        .d_ack(dAckB), .d_rdata(dRdataB),
        .mem_en(memEnB), .mem_we(memWeB), .mem_addr(memAddrB), .mem_wdata(memWdataB),
        .mem_rdata(memRdata), .busy(busyB), .stall(stallB)
    );

    pl_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(3)) u_dutC (
        .clock(clock), .reset(reset),
        .i_req(iReq), .i_addr(iAddr), .i_ack(iAckC), .i_rdata(iRdataC),
        .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
        .d_ack(dAckC), .d_rdata(dRdataC),
        .mem_en(memEnC), .mem_we(memWeC), .mem_addr(memAddrC), .mem_wdata(memWdataC),
        .mem_rdata(memRdata), .busy(busyC), .stall(stallC)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one cycle; sampling and driving happen 2 units after the rising edge.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Pulse reset with all requests low, leaving the arbiters idle.
    task automatic doReset();
        iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Reset held with both requests high, then D is granted straight after release.
    task automatic test_reset();
        reset = 1'b1;
        iReq = 1'b1; iAddr = 32'h100;
        dReq = 1'b1; dWe = 1'b1; dAddr = 32'h44; dWdata = 32'h99;
        memRdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            tick();
            nChecks++;
            if ({iAckA, dAckA, memEnA, memWeA, busyA} !== 5'b0) begin
                nFails++;
                $display("[TB] FAIL reset_ctrl cycle %0d: got %b expected 00000", k,
                         {iAckA, dAckA, memEnA, memWeA, busyA});
            end
            nChecks++;
            if ({memAddrA, memWdataA, iRdataA, dRdataA} !== 128'h0) begin
                nFails++;
                $display("[TB] FAIL reset_data cycle %0d: addr %h wdata %h irdata %h drdata %h expected all 0",
                         k, memAddrA, memWdataA, iRdataA, dRdataA);
            end
        end
        reset = 1'b0;
        tick();
        nChecks++;
        if ({memEnA, memWeA, memAddrA, memWdataA} !== {1'b1, 1'b1, 32'h44, 32'h99}) begin
            nFails++;
            $display("[TB] FAIL reset_first_grant: en %b we %b addr %h wdata %h expected 1 1 00000044 00000099",
                     memEnA, memWeA, memAddrA, memWdataA);
        end
        tick();
        nChecks++;
        if ({dAckA, iAckA} !== 2'b10) begin
            nFails++;
            $display("[TB] FAIL reset_first_ack: d_ack %b i_ack %b expected 1 0", dAckA, iAckA);
        end
        iReq = 1'b0; dReq = 1'b0;
        tick();
    endtask

    // Single fetch on the latency-2 instance; read data is only valid in cycle 3.
    task automatic test_single_fetch();
        doReset();
        memRdata = 32'h0;
        iAddr = 32'h10; iReq = 1'b1;
        #1;
        nChecks++;
        if (stallA !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL fetch_stall_c0: got %b expected 1", stallA);
        end
        for (int c = 1; c <= 5; c++) begin
            tick();
            nChecks++;
            if (memEnA !== (c == 1)) begin
                nFails++;
                $display("[TB] FAIL fetch_mem_en cycle %0d: got %b expected %b", c, memEnA, (c == 1));
            end
            nChecks++;
            if (iAckA !== (c == 4)) begin
                nFails++;
                $display("[TB] FAIL fetch_i_ack cycle %0d: got %b expected %b", c, iAckA, (c == 4));
            end
            nChecks++;
            if (stallA !== (c <= 3)) begin
                nFails++;
                $display("[TB] FAIL fetch_stall cycle %0d: got %b expected %b", c, stallA, (c <= 3));
            end
            if (c == 1) begin
                nChecks++;
                if ({memAddrA, memWeA} !== {32'h10, 1'b0}) begin
                    nFails++;
                    $display("[TB] FAIL fetch_mem_addr: addr %h we %b expected 00000010 0", memAddrA, memWeA);
                end
            end
            if (c >= 4) begin
                nChecks++;
                if (iRdataA !== 32'hDEADBEEF) begin
                    nFails++;
                    $display("[TB] FAIL fetch_i_rdata cycle %0d: got %h expected deadbeef", c, iRdataA);
                end
            end
            memRdata = (c == 3) ? 32'hDEADBEEF : 32'h0;
            if (c == 4) iReq = 1'b0;
        end
        nChecks++;
        if (busyA !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL fetch_busy_after: got %b expected 0", busyA);
        end
    endtask

    // Data write completes in two cycles with no fetch acknowledge.
    task automatic test_data_write();
        doReset();
        dReq = 1'b1; dWe = 1'b1; dAddr = 32'h20; dWdata = 32'h55;
        tick();
        nChecks++;
        if ({memEnA, memWeA, memAddrA, memWdataA, dAckA} !== {1'b1, 1'b1, 32'h20, 32'h55, 1'b0}) begin
            nFails++;
            $display("[TB] FAIL write_issue: en %b we %b addr %h wdata %h d_ack %b expected 1 1 00000020 00000055 0",
                     memEnA, memWeA, memAddrA, memWdataA, dAckA);
        end
        tick();
        nChecks++;
        if ({dAckA, iAckA, memEnA} !== 3'b100) begin
            nFails++;
            $display("[TB] FAIL write_ack: d_ack %b i_ack %b mem_en %b expected 1 0 0", dAckA, iAckA, memEnA);
        end
        dReq = 1'b0; dWe = 1'b0;
        tick();
        nChecks++;
        if ({dAckA, busyA} !== 2'b00) begin
            nFails++;
            $display("[TB] FAIL write_done: d_ack %b busy %b expected 0 0", dAckA, busyA);
        end
    endtask

    // Both ports held busy: with STARVE_MAX=3 the grant order is D,D,D,I repeating.
    task automatic test_contention();
        int expD [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
        int grants = 0, iAcks = 0, dAcks = 0, overlap = 0, adjEn = 0, cycles = 0;
        logic prevEn = 1'b0;
        logic [31:0] wantAddr;
        doReset();
        iAddr = 32'h100; dAddr = 32'h200; dWe = 1'b1; dWdata = 32'h77; memRdata = 32'h1234;
        iReq = 1'b1; dReq = 1'b1;
        while ((iAcks + dAcks) < 8 && cycles < 200) begin
            tick();
            cycles++;
            if (memEnA) begin
                if (grants < 8) begin
                    wantAddr = (expD[grants] == 1) ? 32'h200 : 32'h100;
                    nChecks++;
                    if (memAddrA !== wantAddr) begin
                        nFails++;
                        $display("[TB] FAIL contention_grant %0d: addr %h expected %h", grants, memAddrA, wantAddr);
                    end
                end
                grants++;
                if (prevEn) adjEn++;
            end
            if (iAckA) iAcks++;
            if (dAckA) dAcks++;
            if (iAckA && dAckA) overlap++;
            prevEn = memEnA;
        end
        iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
        nChecks++;
        if (cycles >= 200) begin
            nFails++;
            $display("[TB] FAIL contention_timeout: acks %0d expected 8 within 200 cycles", iAcks + dAcks);
        end
        nChecks++;
        if ({grants, iAcks, dAcks} !== {32'd8, 32'd2, 32'd6}) begin
            nFails++;
            $display("[TB] FAIL contention_counts: grants %0d i_acks %0d d_acks %0d expected 8 2 6",
                     grants, iAcks, dAcks);
        end
        nChecks++;
        if ({overlap, adjEn} !== 64'd0) begin
            nFails++;
            $display("[TB] FAIL contention_overlap: overlapping acks %0d adjacent mem_en %0d expected 0 0",
                     overlap, adjEn);
        end
        tick();
        tick();
    endtask

    // Reset in the middle of a latency-4 fetch abandons it; the next fetch is normal.
    task automatic test_reset_mid_read();
        int spurious = 0;
        doReset();
        memRdata = 32'h12345678; iAddr = 32'h30; iReq = 1'b1;
        tick();
        nChecks++;
        if ({memEnB, memAddrB} !== {1'b1, 32'h30}) begin
            nFails++;
            $display("[TB] FAIL midreset_issue: en %b addr %h expected 1 00000030", memEnB, memAddrB);
        end
        tick();
        tick();
        reset = 1'b1;
        #1;
        nChecks++;
        if ({iAckB, busyB, iRdataB} !== {1'b0, 1'b0, 32'h0}) begin
            nFails++;
            $display("[TB] FAIL midreset_clear: i_ack %b busy %b i_rdata %h expected 0 0 00000000",
                     iAckB, busyB, iRdataB);
        end
        tick();
        iReq = 1'b0; reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (iAckB) spurious++;
        end
        nChecks++;
        if ({spurious, iRdataB} !== {32'd0, 32'h0}) begin
            nFails++;
            $display("[TB] FAIL midreset_no_ack: acks %0d i_rdata %h expected 0 00000000", spurious, iRdataB);
        end
        memRdata = 32'hCAFEF00D; iAddr = 32'h34; iReq = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            nChecks++;
            if (iAckB !== (c == 6)) begin
                nFails++;
                $display("[TB] FAIL midreset_refetch_ack cycle %0d: got %b expected %b", c, iAckB, (c == 6));
            end
        end
        nChecks++;
        if (iRdataB !== 32'hCAFEF00D) begin
            nFails++;
            $display("[TB] FAIL midreset_refetch_data: got %h expected cafef00d", iRdataB);
        end
        iReq = 1'b0;
        tick();
    endtask

    // Latency-1 fetches with i_req held: one idle cycle separates transactions.
    task automatic test_back_to_back();
        doReset();
        memRdata = 32'hA5A5A5A5; iAddr = 32'h40; iReq = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            nChecks++;
            if (memEnC !== (c == 1 || c == 5)) begin
                nFails++;
                $display("[TB] FAIL b2b_mem_en cycle %0d: got %b expected %b", c, memEnC, (c == 1 || c == 5));
            end
            nChecks++;
            if (iAckC !== (c == 3 || c == 7)) begin
                nFails++;
                $display("[TB] FAIL b2b_i_ack cycle %0d: got %b expected %b", c, iAckC, (c == 3 || c == 7));
            end
        end
        iReq = 1'b0;
        tick();
        nChecks++;
        if ({busyC, iRdataC} !== {1'b0, 32'hA5A5A5A5}) begin
            nFails++;
            $display("[TB] FAIL b2b_end: busy %b i_rdata %h expected 0 a5a5a5a5", busyC, iRdataC);
        end
    endtask

    // Run the scenarios in order and report.
    initial begin
        reset = 1'b1;
        iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
        iAddr = '0; dAddr = '0; dWdata = '0; memRdata = '0;
        test_reset();
        test_single_fetch();
        test_data_write();
        test_contention();
        test_reset_mid_read();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Guard against a hung simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pl_mem_arbiter.md
Name: pl_mem_arbiter

Overview:
- Shares one single-port synchronous memory between the pipelined CPU's instruction-fetch port (I, read-only) and data port (D, read/write).
- Sits between the `pl_computer` IF/MEM stages and the unified memory.
- Grants one transaction at a time and returns a one-cycle acknowledge with read data.
- Drives a stall indication so the pipeline freezes while a requester waits.

Parameters:
- AW, 32: address width in bits.
- DW, 32: data width in bits.
- MEM_LAT, 2: memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.
- STARVE_MAX, 4: maximum consecutive D grants while I is pending before I is forced; legal range 1..15.

Ports:
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held high until i_ack.
- i_addr  in  AW  fetch address; stable while i_req is high.
- i_ack  out  1  one-cycle pulse; fetch complete, i_rdata valid.
- i_rdata  out  DW  fetch data; held until the next i_ack.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_ack  out  1  one-cycle pulse; data transaction complete.
- d_rdata  out  DW  read data; held until the next read d_ack.
- mem_en  out  1  memory access strobe, exactly one cycle per transaction.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  AW  registered memory address.
- mem_wdata  out  DW  registered memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high in any state other than IDLE.
- stall  out  1  combinational; (i_req & ~i_ack) | (d_req & ~d_ack).

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All outputs are 0: i_ack, d_ack, mem_en, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata, busy.
  - Latency counter and starvation counter clear to 0.
- Reset mid-transaction: the transaction is abandoned, no ack is issued, and any late mem_rdata is ignored.
- FSM states: IDLE, ISSUE, WAIT, ACK. One outstanding transaction at a time.
- IDLE:
  - If any req is high at a rising edge, go to ISSUE.
  - Register the winner (owner), mem_addr, mem_wdata and mem_we (0 for I).
- Arbitration:
  - Only D requesting: grant D. Only I requesting: grant I.
  - Both requesting: D wins unless starve_cnt == STARVE_MAX, in which case I wins.
- Starvation counter:
  - Increments on a D grant made while i_req is high, saturating at STARVE_MAX.
  - Clears on any I grant.
  - Holds otherwise.
- ISSUE:
  - mem_en = 1 for exactly this cycle.
  - Write: next state is ACK.
  - Read: next state is WAIT, with the latency counter loaded to MEM_LAT-1.
- WAIT:
  - Decrement the latency counter each cycle.
  - When it reaches 0, capture mem_rdata into i_rdata or d_rdata (per owner) and go to ACK.
  - With MEM_LAT = 1, WAIT lasts one cycle.
- ACK:
  - Assert the owner's ack for one cycle, then return to IDLE.
  - Requests are ignored in ACK. A requester holding req after ack is treated as a new request at the next IDLE evaluation.
- Latency, counting req first high in cycle 0 with the FSM in IDLE:
  - mem_en in cycle 1.
  - Write ack in cycle 2.
  - Read ack in cycle MEM_LAT+2.
  - Next grant no earlier than the cycle after ack (one idle cycle between transactions).
- i_ack and d_ack are never high in the same cycle.
- mem_en is never high in consecutive cycles.
- Requests that drop before ack violate the protocol. The arbiter completes the granted transaction anyway.
- Changing address or data while req is high is ignored after grant, because values are registered at grant.

Decomposition:
- Package `pl_arb_pkg` holds:
  - state enum (IDLE, ISSUE, WAIT, ACK);
  - owner encoding (OWN_I = 0, OWN_D = 1);
  - counter width constant CNT_W = 4.
- One natural sub-module, `pl_lat_counter`: loadable down-counter with load, enable and a zero flag. It is reused for the latency countdown.
- The starvation counter stays inline.

Test Plan:
- Reset values: assert reset for 3 cycles with both reqs high -> all outputs 0 and no mem_en. Deassert reset -> D granted first, mem_en in the first cycle after deassert.
- Single fetch: MEM_LAT=2, i_req with i_addr=0x10, memory returns 0xDEADBEEF -> mem_en in cycle 1 with mem_addr=0x10, i_ack in cycle 4, i_rdata=0xDEADBEEF, stall high in cycles 0-3.
- Data write: d_req, d_we=1, d_addr=0x20, d_wdata=0x55 -> mem_en=mem_we=1 in cycle 1, d_ack in cycle 2, no i_ack.
- Contention: i_req and d_req held continuously with STARVE_MAX=3 -> grant order D,D,D,I,D,D,D,I, with exactly one ack per transaction and no overlapping acks.
- Reset mid-read: MEM_LAT=4, assert reset in cycle 3 of a fetch -> no i_ack, i_rdata=0, busy=0. A subsequent fetch completes normally in MEM_LAT+2 cycles.
- MEM_LAT=1 back-to-back fetches with i_req held -> i_ack in cycle 3, next mem_en in cycle 5, next i_ack in cycle 7.
